// File: rtl/reaction_pkg.sv
// -----------------------------------------------------------------------------
// reaction_pkg
// Shared definitions for the reaction timer: FSM state encoding, counter
// widths, random-delay constants and the LFSR feedback helper.
// -----------------------------------------------------------------------------
package reaction_pkg;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_DELAY   = 2'd1,
        S_MEASURE = 2'd2,
        S_RESULT  = 2'd3
    } state_t;

    // Width of the millisecond counter and of the result bus.
    localparam int MS_W = 14;

    // Random delay = DELAY_BASE + LFSR[DELAY_MASK_W-1:0] ms, i.e. 1000..2023 ms.
    localparam int DELAY_BASE   = 1000;
    localparam int DELAY_MASK_W = 10;

    // Fibonacci LFSR, taps 16,14,13,11 -> register bits 15,13,12,10.
    localparam int          LFSR_W    = 16;
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    // Shift left; the XOR of the tapped bits enters at bit 0.
    function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] v);
        return {v[LFSR_W-2:0], ^(v & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/reaction_timer_if.sv
// -----------------------------------------------------------------------------
// reaction_timer_if
// Groups the user-facing signals of the reaction timer.
//   start, resp : button levels (debounced, clk-synchronous)
//   led         : stimulus lamp
//   busy        : trial in progress (DELAY or MEASURE)
//   done        : one-cycle pulse when result/early/timeout take new values
//   result      : reaction time in ms
//   early       : false start
//   timeout     : no response before the measurement ceiling
// Modports: master = the user/driver side, slave = the timer.
// -----------------------------------------------------------------------------
interface reaction_timer_if;
    import reaction_pkg::*;

    logic            start;
    logic            resp;
    logic            led;
    logic            busy;
    logic            done;
    logic [MS_W-1:0] result;
    logic            early;
    logic            timeout;

    modport master (
        output start, resp,
        input  led, busy, done, result, early, timeout
    );

    modport slave (
        input  start, resp,
        output led, busy, done, result, early, timeout
    );

endinterface

// File: rtl/ms_tick.sv
// -----------------------------------------------------------------------------
// ms_tick
// Millisecond prescaler. Counts 0..TICK_DIV-1 and raises tick for the one
// cycle in which the count sits at TICK_DIV-1, then wraps to 0.
//   clk   : system clock
//   rst_n : asynchronous active-low reset
//   clr   : synchronous clear; holds the count at 0 while asserted
//   tick  : one-cycle pulse every TICK_DIV cycles
// -----------------------------------------------------------------------------
module ms_tick #(
    parameter int TICK_DIV = 100000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    output logic tick
);

    localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    logic [CW-1:0] cnt;

    assign tick = (cnt == CW'(TICK_DIV - 1));

    // NOTE: clocked state uses non-blocking assignments so every register
    // samples pre-edge values and simulation matches the synthesized flops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr || tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/reaction_timer.sv
// -----------------------------------------------------------------------------
// reaction_timer
// Human reaction-time tester. A start edge launches a random 1000..2023 ms
// delay; the lamp then lights and the time to the response edge is measured
// in ms. A response during the delay is a false start; no response before
// MAX_MS is a timeout.
//   clk    : system clock
//   rst_n  : asynchronous active-low reset
//   bus    : reaction_timer_if.slave (start/resp in; led, busy, done,
//            result, early, timeout out -- all outputs registered)
// -----------------------------------------------------------------------------
module reaction_timer
    import reaction_pkg::*;
#(
    parameter int          TICK_DIV  = 100000,
    parameter int          MAX_MS    = 9999,
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic              clk,
    input  logic              rst_n,
    reaction_timer_if.slave   bus
);

    state_t            state, state_d;
    logic [LFSR_W-1:0] lfsr;
    logic              start_q, resp_q;
    logic              armed;
    logic [MS_W-1:0]   ms_cnt, ms_d;
    logic [MS_W-1:0]   target, target_d;

    logic              led_q, busy_q, done_q, early_q, timeout_q;
    logic              led_d, busy_d, done_d, early_d, timeout_d;
    logic [MS_W-1:0]   result_q, result_d;

    logic              start_edge, resp_edge;
    logic              tick, clr;

    // armed is low for the first cycle after reset so a button already held
    // through reset release cannot masquerade as a fresh edge while the edge
    // register catches up with it.
    assign start_edge = bus.start & ~start_q & armed;
    assign resp_edge  = bus.resp  & ~resp_q  & armed;

    ms_tick #(.TICK_DIV(TICK_DIV)) u_ms_tick (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (clr),
        .tick  (tick)
    );

    // NOTE: every signal driven here gets a default first, so no path
    // through the case leaves a value unassigned and no latch is inferred.
    always_comb begin
        state_d   = state;
        ms_d      = ms_cnt;
        target_d  = target;
        result_d  = result_q;
        early_d   = early_q;
        timeout_d = timeout_q;
        done_d    = 1'b0;

        case (state)
            S_IDLE, S_RESULT: begin
                if (start_edge) begin
                    state_d   = S_DELAY;
                    result_d  = '0;
                    early_d   = 1'b0;
                    timeout_d = 1'b0;
                    ms_d      = '0;
                    target_d  = MS_W'(DELAY_BASE) + MS_W'(lfsr[DELAY_MASK_W-1:0]);
                end
            end

            S_DELAY: begin
                // A response beats a delay expiry landing in the same cycle.
                if (resp_edge) begin
                    state_d  = S_RESULT;
                    early_d  = 1'b1;
                    result_d = '0;
                    done_d   = 1'b1;
                end else if (tick) begin
                    if (ms_cnt == target - 1'b1) begin
                        state_d = S_MEASURE;
                        ms_d    = '0;
                    end else begin
                        ms_d = ms_cnt + 1'b1;
                    end
                end
            end

            S_MEASURE: begin
                // On a response the count already registered is reported; a
                // tick in the same cycle is not added.
                if (resp_edge) begin
                    state_d  = S_RESULT;
                    result_d = ms_cnt;
                    done_d   = 1'b1;
                end else if (tick) begin
                    if (ms_cnt == MS_W'(MAX_MS - 1)) begin
                        state_d   = S_RESULT;
                        result_d  = MS_W'(MAX_MS);
                        timeout_d = 1'b1;
                        done_d    = 1'b1;
                    end else begin
                        ms_d = ms_cnt + 1'b1;
                    end
                end
            end

            default: state_d = S_IDLE;
        endcase

        led_d  = (state_d == S_MEASURE);
        busy_d = (state_d == S_DELAY) || (state_d == S_MEASURE);

        // The prescaler restarts from 0 on entry to DELAY or MEASURE and
        // rests at 0 in every other state.
        clr = !busy_d || (state_d != state);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            lfsr      <= LFSR_SEED;
            start_q   <= 1'b0;
            resp_q    <= 1'b0;
            armed     <= 1'b0;
            ms_cnt    <= '0;
            target    <= '0;
            led_q     <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            result_q  <= '0;
            early_q   <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state     <= state_d;
            lfsr      <= lfsr_next(lfsr);
            start_q   <= bus.start;
            resp_q    <= bus.resp;
            armed     <= 1'b1;
            ms_cnt    <= ms_d;
            target    <= target_d;
            led_q     <= led_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            result_q  <= result_d;
            early_q   <= early_d;
            timeout_q <= timeout_d;
        end
    end

    assign bus.led     = led_q;
    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
    assign bus.result  = result_q;
    assign bus.early   = early_q;
    assign bus.timeout = timeout_q;

endmodule
